// File: rtl/riscv_clint.sv
// Core-local interruptor: 64-bit mtime/mtimecmp with a level timer interrupt.
// Optional mtime prescaler is built only when RISCV_CLINT_PRESCALE_EN is defined.
`timescale 1ns/1ps
module riscv_clint #(
  parameter logic [31:0] BASE     = 32'h0200_0000,
  parameter int unsigned PRESCALE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [2:0]  mem_op,
  input  logic [31:0] data_o,
  output logic [31:0] rdata,
  output logic        sel,
  output logic        timer_irq
);

  if (PRESCALE < 1 || PRESCALE > 65535) begin : g_bad_prescale
    $error("riscv_clint: PRESCALE out of range");
  end

  localparam logic [15:0] WIN = BASE[31:16];

  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic        tick;
  logic        in_win;
  logic        is_st;
  logic [13:0] word;
  logic        hit_cl;
  logic        hit_ch;
  logic        hit_tl;
  logic        hit_th;
  logic [3:0]  mask;
  logic        aligned;
  logic        wr_ok;

  assign in_win = (addr[31:16] == WIN);
  assign sel    = in_win && (mem_op != 3'b000);
  assign is_st  = sel && mem_op[2];
  assign word   = addr[15:2];
  assign hit_cl = (word == 14'h1000);
  assign hit_ch = (word == 14'h1001);
  assign hit_tl = (word == 14'h2FFE);
  assign hit_th = (word == 14'h2FFF);

  // Byte-lane mask and alignment from access size and low address bits
  always_comb begin
    mask    = 4'b0000;
    aligned = 1'b0;
    unique case (mem_op[1:0])
      2'b01: begin
        mask    = 4'b0001 << addr[1:0];
        aligned = 1'b1;
      end
      2'b10: begin
        mask    = addr[1] ? 4'b1100 : 4'b0011;
        aligned = ~addr[0];
      end
      2'b11: begin
        mask    = 4'b1111;
        aligned = (addr[1:0] == 2'b00);
      end
      default: begin
        mask    = 4'b0000;
        aligned = 1'b0;
      end
    endcase
  end

  assign wr_ok = is_st && aligned && (mask != 4'b0000);

  function automatic logic [31:0] merge(
    input logic [31:0] old_v,
    input logic [31:0] new_v,
    input logic [3:0]  m
  );
    logic [31:0] r;
    for (int i = 0; i < 4; i++)
      r[i*8 +: 8] = m[i] ? new_v[i*8 +: 8] : old_v[i*8 +: 8];
    return r;
  endfunction

  // Full aligned word read, zero when unselected or unmapped
  always_comb begin
    rdata = 32'h0;
    if (sel) begin
      unique case (1'b1)
        hit_cl:  rdata = mtimecmp[31:0];
        hit_ch:  rdata = mtimecmp[63:32];
        hit_tl:  rdata = mtime[31:0];
        hit_th:  rdata = mtime[63:32];
        default: rdata = 32'h0;
      endcase
    end
  end

`ifdef RISCV_CLINT_PRESCALE_EN
  localparam logic [15:0] PMAX = 16'(PRESCALE - 1);
  logic [15:0] pcnt;

  // Free-running prescaler, unaffected by mtime writes
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               pcnt <= 16'h0;
    else if (pcnt == PMAX) pcnt <= 16'h0;
    else                   pcnt <= pcnt + 16'h1;
  end

  assign tick = (pcnt == PMAX);
`else
  assign tick = 1'b1;
`endif

  // mtime: a store to either half wins over the tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtime <= 64'h0;
    end else if (wr_ok && hit_tl) begin
      mtime[31:0] <= merge(mtime[31:0], data_o, mask);
    end else if (wr_ok && hit_th) begin
      mtime[63:32] <= merge(mtime[63:32], data_o, mask);
    end else if (tick) begin
      mtime <= mtime + 64'h1;
    end
  end

  // mtimecmp byte-lane stores
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtimecmp <= '1;
    end else if (wr_ok && hit_cl) begin
      mtimecmp[31:0] <= merge(mtimecmp[31:0], data_o, mask);
    end else if (wr_ok && hit_ch) begin
      mtimecmp[63:32] <= merge(mtimecmp[63:32], data_o, mask);
    end
  end

  // Registered level compare on current register values
  always_ff @(posedge clk or posedge rst) begin
    if (rst) timer_irq <= 1'b0;
    else     timer_irq <= (mtime >= mtimecmp);
  end

endmodule

// File: tb/tb_riscv_clint.sv
// Directed self-checking bench for riscv_clint.
// Tick period follows RISCV_CLINT_PRESCALE_EN (PRESCALE=4 when defined).
`timescale 1ns/1ps
module tb_riscv_clint;

`ifdef RISCV_CLINT_PRESCALE_EN
  localparam int PS = 4;
`else
  localparam int PS = 1;
`endif
  localparam logic [31:0] B  = 32'h0200_0000;
  localparam logic [2:0]  SW = 3'b111;
  localparam logic [2:0]  SH = 3'b110;
  localparam logic [2:0]  SB = 3'b101;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = 32'h0;
  logic [2:0]  mem_op = 3'b000;
  logic [31:0] data_o = 32'h0;
  logic [31:0] rdata;
  logic        sel;
  logic        timer_irq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  riscv_clint #(.BASE(B), .PRESCALE(PS)) dut (
    .clk(clk), .rst(rst), .addr(addr), .mem_op(mem_op),
    .data_o(data_o), .rdata(rdata), .sel(sel), .timer_irq(timer_irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rd(input logic [15:0] off, output logic [31:0] v);
    addr = B + {16'h0, off};
    mem_op = 3'b011;
    #1;
    v = rdata;
    mem_op = 3'b000;
  endtask

  task automatic st(input logic [31:0] a, input logic [2:0] op,
                    input logic [31:0] d);
    addr = a;
    mem_op = op;
    data_o = d;
    @(posedge clk);
    #1;
    mem_op = 3'b000;
  endtask

  task automatic sync_tick();
    logic [31:0] v0, v;
    bit seen;
    seen = 0;
    rd(16'hBFF8, v0);
    for (int i = 0; i < 64; i++) begin
      step();
      rd(16'hBFF8, v);
      if (v != v0) begin
        seen = 1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $error("FAIL sync_tick: got no tick expected tick within 64 cycles");
    end
    step(PS - 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    bit found;

    step(3);
    rst = 1'b0;
    step(7);
    #2 rst = 1'b1;
    #1;
    rd(16'hBFF8, v); chk("rst_mtime_lo", v, 32'h0);
    rd(16'hBFFC, v); chk("rst_mtime_hi", v, 32'h0);
    rd(16'h4000, v); chk("rst_cmp_lo", v, 32'hFFFF_FFFF);
    chk("rst_irq", {31'b0, timer_irq}, 32'h0);
    step(2);
    rst = 1'b0;
    rd(16'hBFF8, v); chk("post_rst_lo", v, 32'h0);

    step(40);
    rd(16'hBFF8, v); chk("prescale_40", v, 32'(40 / PS));

    addr = B + 32'h4000; mem_op = 3'b011; #1;
    chk("sel_load", {31'b0, sel}, 32'h1);
    mem_op = 3'b000; #1;
    chk("sel_none", {31'b0, sel}, 32'h0);
    addr = B + 32'h0001_4000; mem_op = 3'b011; #1;
    chk("sel_outside", {31'b0, sel}, 32'h0);
    chk("rdata_outside", rdata, 32'h0);
    mem_op = 3'b000;
    rd(16'h0000, v); chk("rd_unmapped", v, 32'h0);

    st(B + 32'hBFF8, SW, 32'h0);
    st(B + 32'h4000, SW, 32'd10);
    st(B + 32'h4004, SW, 32'h0);
    found = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      rd(16'hBFF8, v);
      if (v == 32'd10) begin
        found = 1;
        break;
      end
    end
    if (!found) begin
      checks++;
      errors++;
      $error("FAIL cmp_reach: got no mtime=10 expected within 200 cycles");
    end
    chk("cmp_irq_before", {31'b0, timer_irq}, 32'h0);
    step();
    chk("cmp_irq_rise", {31'b0, timer_irq}, 32'h1);
    st(B + 32'h4004, SW, 32'h1);
    chk("cmp_irq_hold", {31'b0, timer_irq}, 32'h1);
    step();
    chk("cmp_irq_drop", {31'b0, timer_irq}, 32'h0);

    sync_tick();
    st(B + 32'hBFF8, SW, 32'h100);
    rd(16'hBFF8, v); chk("collide_lo", v, 32'h100);
    rd(16'hBFFC, v); chk("collide_hi", v, 32'h0);
    st(B + 32'hBFFC, SW, 32'h7);
    rd(16'hBFFC, v); chk("mtime_hi_wr", v, 32'h7);

    st(B + 32'h4000, SW, 32'hFFFF_FFFF);
    st(B + 32'h4004, SW, 32'hFFFF_FFFF);
    st(B + 32'h4001, SB, 32'h0000_5500);
    rd(16'h4000, v); chk("sb_lane1", v, 32'hFFFF_55FF);
    st(B + 32'h4001, SH, 32'h1234_5678);
    rd(16'h4000, v); chk("sh_misalign", v, 32'hFFFF_55FF);
    st(B + 32'h0001_4001, SB, 32'h0000_AA00);
    rd(16'h4000, v); chk("sb_outside", v, 32'hFFFF_55FF);
    st(B + 32'h4002, SH, 32'hABCD_0000);
    rd(16'h4000, v); chk("sh_upper", v, 32'hABCD_55FF);
    rd(16'h4004, v); chk("cmp_hi_keep", v, 32'hFFFF_FFFF);

    st(B + 32'h4000, SW, 32'd5);
    st(B + 32'h4004, SW, 32'h0);
    st(B + 32'hBFFC, SW, 32'hFFFF_FFFF);
    sync_tick();
    st(B + 32'hBFF8, SW, 32'hFFFF_FFFF);
    chk("wrap_irq_hi", {31'b0, timer_irq}, 32'h1);
    rd(16'hBFF8, v); chk("wrap_all1_lo", v, 32'hFFFF_FFFF);
    rd(16'hBFFC, v); chk("wrap_all1_hi", v, 32'hFFFF_FFFF);
    step(PS);
    rd(16'hBFF8, v); chk("wrap_lo0", v, 32'h0);
    rd(16'hBFFC, v); chk("wrap_hi0", v, 32'h0);
    chk("wrap_irq_lag", {31'b0, timer_irq}, 32'h1);
    step();
    chk("wrap_irq_drop", {31'b0, timer_irq}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
